// File: rtl/return_addr_stack_pkg.sv
// Shared constants and types for the return-address stack.
// Mode selectors, the push/pop op encoding and width helpers.
package return_addr_stack_pkg;

    localparam int RAS_SATURATE = 0;
    localparam int RAS_WRAP     = 1;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } ras_op_e;

    function automatic int ras_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ras_mem.sv
// Return-address storage: DEPTH x ADDR_W registers,
// one synchronous write port and one asynchronous read port.
module ras_mem #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [PW-1:0]     i_waddr,
    input  logic [ADDR_W-1:0] i_wdata,
    input  logic [PW-1:0]     i_raddr,
    output logic [ADDR_W-1:0] o_rdata
);

    logic [ADDR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Return-address stack: call pushes PC+1, return pops; the top
// entry drives the fetch next-PC mux combinationally.
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int WRAP   = RAS_SATURATE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic                         clr_flags,
    input  logic [ADDR_W-1:0]            addr_in,
    output logic [ADDR_W-1:0]            addr_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = ras_ptr_w(DEPTH);
    localparam int CW = ras_cnt_w(DEPTH);

    logic [PW-1:0]     r_tp;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_unf;

    logic              w_empty;
    logic              w_full;
    logic              w_we;
    logic [PW-1:0]     w_waddr;
    logic [PW-1:0]     w_tp_n;
    logic [CW-1:0]     w_cnt_n;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic [ADDR_W-1:0] w_rdata;
    ras_op_e           w_op;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_op    = ras_op_e'({push, pop});

    always_comb begin
        w_we      = 1'b0;
        w_waddr   = r_tp;
        w_tp_n    = r_tp;
        w_cnt_n   = r_count;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (flush) begin
            w_tp_n  = '0;
            w_cnt_n = '0;
        end else begin
            unique case (w_op)
                OP_PUSH: begin
                    if (!w_full) begin
                        w_tp_n  = r_tp + PW'(1);
                        w_we    = 1'b1;
                        w_waddr = r_tp + PW'(1);
                        w_cnt_n = r_count + CW'(1);
                    end else begin
                        w_set_ovf = 1'b1;
                        // tp+1 is the oldest slot once the ring is full
                        if (WRAP == RAS_WRAP) begin
                            w_tp_n  = r_tp + PW'(1);
                            w_we    = 1'b1;
                            w_waddr = r_tp + PW'(1);
                        end
                    end
                end
                OP_POP: begin
                    if (!w_empty) begin
                        w_tp_n  = r_tp - PW'(1);
                        w_cnt_n = r_count - CW'(1);
                    end else begin
                        w_set_unf = 1'b1;
                    end
                end
                OP_BOTH: begin
                    if (!w_empty) begin
                        w_we = 1'b1;
                    end else begin
                        w_tp_n    = r_tp + PW'(1);
                        w_we      = 1'b1;
                        w_waddr   = r_tp + PW'(1);
                        w_cnt_n   = CW'(1);
                        w_set_unf = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_tp    <= w_tp_n;
            r_count <= w_cnt_n;
            if (w_set_ovf)      r_ovf <= 1'b1;
            else if (clr_flags) r_ovf <= 1'b0;
            if (w_set_unf)      r_unf <= 1'b1;
            else if (clr_flags) r_unf <= 1'b0;
        end
    end

    ras_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PW     (PW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (addr_in),
        .i_raddr (r_tp),
        .o_rdata (w_rdata)
    );

    assign addr_out  = w_empty ? '0 : w_rdata;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench for return_addr_stack: saturating and wrapping
// instances share stimulus; pop results go through a scoreboard.
module tb_return_addr_stack;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic        pop;
    logic        flush;
    logic        clr_flags;
    logic [11:0] addr_in;

    logic [11:0] a_addr, b_addr;
    logic [3:0]  a_cnt, b_cnt;
    logic        a_emp, b_emp, a_full, b_full;
    logic        a_ovf, b_ovf, a_unf, b_unf;

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] qa[$];
    logic [11:0] qb[$];

    always #5 clk = ~clk;

    return_addr_stack #(.ADDR_W(12), .DEPTH(8), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
        .clr_flags(clr_flags), .addr_in(addr_in), .addr_out(a_addr),
        .count(a_cnt), .empty(a_emp), .full(a_full),
        .overflow(a_ovf), .underflow(a_unf)
    );

    return_addr_stack #(.ADDR_W(12), .DEPTH(8), .WRAP(1)) u_wrp (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
        .clr_flags(clr_flags), .addr_in(addr_in), .addr_out(b_addr),
        .count(b_cnt), .empty(b_emp), .full(b_full),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_flags = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr_in = '0;
        idle();
        #3;
        chk("rst_cnt",   32'(a_cnt),  0);
        chk("rst_empty", 32'(a_emp),  1);
        chk("rst_full",  32'(a_full), 0);
        chk("rst_addr",  32'(a_addr), 0);
        #9 rst = 1'b0;
        tick();

        // pop on empty sets underflow
        pop = 1'b1; tick(); idle();
        chk("pop_empty_unf", 32'(a_unf), 1);
        chk("pop_empty_cnt", 32'(a_cnt), 0);
        clr_flags = 1'b1; tick(); idle();
        chk("clr_unf", 32'(a_unf), 0);

        // async reset mid-operation
        pop = 1'b1; tick(); idle();
        push = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            addr_in = 12'(i); tick();
        end
        idle();
        chk("pre_rst_cnt", 32'(a_cnt), 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_cnt",   32'(a_cnt),  0);
        chk("arst_empty", 32'(a_emp),  1);
        chk("arst_addr",  32'(a_addr), 0);
        chk("arst_unf",   32'(a_unf),  0);
        chk("arst_ovf",   32'(a_ovf),  0);
        #1 rst = 1'b0;
        tick();

        // LIFO order
        push = 1'b1;
        addr_in = 12'h010; tick();
        addr_in = 12'h020; tick();
        addr_in = 12'h030; tick();
        idle();
        chk("lifo_top", 32'(a_addr), 32'h030);
        chk("lifo_cnt", 32'(a_cnt), 3);
        pop = 1'b1;
        qa.push_back(12'h020); tick(); chk("lifo_pop1", 32'(a_addr), 32'(qa.pop_front()));
        qa.push_back(12'h010); tick(); chk("lifo_pop2", 32'(a_addr), 32'(qa.pop_front()));
        qa.push_back(12'h000); tick(); chk("lifo_pop3", 32'(a_addr), 32'(qa.pop_front()));
        idle();
        chk("lifo_empty", 32'(a_emp), 1);

        // simultaneous push+pop
        push = 1'b1; addr_in = 12'h020; tick();
        pop = 1'b1; addr_in = 12'h0AA; tick(); idle();
        chk("both_top", 32'(a_addr), 32'h0AA);
        chk("both_cnt", 32'(a_cnt), 1);
        pop = 1'b1; tick(); idle();
        chk("both_drain", 32'(a_emp), 1);
        push = 1'b1; pop = 1'b1; addr_in = 12'h055; tick(); idle();
        chk("both_e_cnt",  32'(a_cnt),  1);
        chk("both_e_unf",  32'(a_unf),  1);
        chk("both_e_addr", 32'(a_addr), 32'h055);
        pop = 1'b1; clr_flags = 1'b1; tick(); idle();
        chk("both_e_clr", 32'(a_unf), 0);

        // saturate vs wrap: push 1..9
        push = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            addr_in = 12'(i); tick();
        end
        idle();
        chk("sat_cnt",  32'(a_cnt),  8);
        chk("sat_full", 32'(a_full), 1);
        chk("sat_ovf",  32'(a_ovf),  1);
        chk("sat_top",  32'(a_addr), 8);
        chk("wrp_cnt",  32'(b_cnt),  8);
        chk("wrp_ovf",  32'(b_ovf),  1);
        chk("wrp_top",  32'(b_addr), 9);
        pop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            qa.push_back(12'(8 - i));
            qb.push_back(12'(9 - i));
            chk("sat_pop", 32'(a_addr), 32'(qa.pop_front()));
            chk("wrp_pop", 32'(b_addr), 32'(qb.pop_front()));
            tick();
        end
        idle();
        chk("sat_drain", 32'(a_emp),  1);
        chk("wrp_drain", 32'(b_emp),  1);
        chk("wrp_unf",   32'(b_unf),  0);
        chk("drain_addr", 32'(b_addr), 0);

        // flush keeps flags
        push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            addr_in = 12'(16 * i); tick();
        end
        idle();
        chk("fl_pre_cnt", 32'(a_cnt), 5);
        flush = 1'b1; push = 1'b1; addr_in = 12'h777;
        #2;
        chk("fl_wait_cnt", 32'(a_cnt), 5);
        tick(); idle();
        chk("fl_cnt",   32'(a_cnt),  0);
        chk("fl_empty", 32'(b_emp),  1);
        chk("fl_addr",  32'(a_addr), 0);
        chk("fl_ovf_a", 32'(a_ovf),  1);
        chk("fl_ovf_b", 32'(b_ovf),  1);
        chk("fl_unf",   32'(a_unf),  0);

        // same-edge set beats clr_flags
        push = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            addr_in = 12'(i); tick();
        end
        clr_flags = 1'b1; addr_in = 12'h0FF; tick(); idle();
        chk("set_wins", 32'(a_ovf), 1);
        chk("wrp_ring_top", 32'(b_addr), 32'h0FF);
        chk("sat_ring_top", 32'(a_addr), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
